// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch handshake between the fetch sequencer (master)
// and the instruction memory (slave).
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_sequencer.sv
// PC sequencer and instruction-fetch handshake for the MIPS core.
// Define FETCH_EXC_EN to add the exception redirect (exc_req/epc, vector EXC_VEC).
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     stall,
    input  logic                     br_req,
    input  logic [31:0]              br_target,
    input  logic                     j_req,
    input  logic [31:0]              j_target,
`ifdef FETCH_EXC_EN
    input  logic                     exc_req,
    output logic [31:0]              epc,
`endif
    fetch_sequencer_if.master        imem,
    output logic                     instr_valid,
    output logic [31:0]              instr,
    output logic [31:0]              instr_pc,
    output logic [31:0]              pc
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, FLUSH} state_t;

    state_t      state;
    logic [31:0] pending;
    logic        redir;
    logic [31:0] redir_tgt;

    // Redirect arbitration: exception over jump over branch.
    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        redir     = j_req | br_req;
        redir_tgt = j_req ? j_target : br_target;
`ifdef FETCH_EXC_EN
        if (exc_req) begin
            redir     = 1'b1;
            redir_tgt = EXC_VEC;
        end
`endif
        redir_tgt[1:0] = 2'b00;
    end

`ifndef FETCH_EXC_EN
    // The vector only matters with the exception feature; keep it referenced.
    wire unused_exc_vec = ^EXC_VEC;
`endif

    assign imem.imem_addr = pc;

    // NOTE: all state here uses <= so every register sees pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            pending       <= '0;
            imem.imem_req <= 1'b0;
            instr_valid   <= 1'b0;
            instr         <= '0;
            instr_pc      <= '0;
`ifdef FETCH_EXC_EN
            epc           <= '0;
`endif
        end else begin
`ifdef FETCH_EXC_EN
            if (exc_req)
                epc <= (state == HOLD) ? instr_pc : pc;
`endif
            case (state)
                IDLE: begin
                    if (redir)
                        pc <= redir_tgt;
                    state         <= REQ;
                    imem.imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem.imem_ack) begin
                        if (redir) begin
                            // Data for the old path is dropped; refetch at the target.
                            pc <= redir_tgt;
                        end else begin
                            instr         <= imem.imem_rdata;
                            instr_pc      <= pc;
                            instr_valid   <= 1'b1;
                            pc            <= pc + 32'd4;
                            state         <= HOLD;
                            imem.imem_req <= 1'b0;
                        end
                    end else if (redir) begin
                        pending <= redir_tgt;
                        state   <= FLUSH;
                    end
                end
                FLUSH: begin
                    // The outstanding fetch must complete before the address can change.
                    if (imem.imem_ack) begin
                        pc    <= redir ? redir_tgt : pending;
                        state <= REQ;
                    end else if (redir) begin
                        pending <= redir_tgt;
                    end
                end
                HOLD: begin
                    if (redir || !stall) begin
                        instr_valid   <= 1'b0;
                        state         <= REQ;
                        imem.imem_req <= 1'b1;
                        if (redir)
                            pc <= redir_tgt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; memory data is addr ^ KEY.
module tb_fetch_sequencer;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        stall;
    logic        br_req;
    logic [31:0] br_target;
    logic        j_req;
    logic [31:0] j_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc;
    logic        auto_ack;
    logic        man_ack;
`ifdef FETCH_EXC_EN
    logic        exc_req;
    logic [31:0] epc;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fetch_sequencer_if imem ();

    assign imem.imem_ack   = auto_ack ? imem.imem_req : man_ack;
    assign imem.imem_rdata = imem.imem_addr ^ KEY;

    fetch_sequencer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .stall       (stall),
        .br_req      (br_req),
        .br_target   (br_target),
        .j_req       (j_req),
        .j_target    (j_target),
`ifdef FETCH_EXC_EN
        .exc_req     (exc_req),
        .epc         (epc),
`endif
        .imem        (imem.master),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .pc          (pc)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b0; stall = 1'b0; br_req = 1'b0; br_target = '0;
        j_req = 1'b0; j_target = '0; auto_ack = 1'b0; man_ack = 1'b0;
`ifdef FETCH_EXC_EN
        exc_req = 1'b0;
`endif
        step();

        // Reset state
        do_reset();
        check("rst_pc", pc, 32'h3000);
        check("rst_req", {31'd0, imem.imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);

        // Zero-wait streaming: valid on every second cycle
        auto_ack = 1'b1;
        step();
        check("zw_first_req", {31'd0, imem.imem_req}, 32'd1);
        check("zw_first_pc", pc, 32'h3000);
        for (int k = 0; k < 3; k++) begin
            step();
            check("zw_valid_hi", {31'd0, instr_valid}, 32'd1);
            check("zw_instr_pc", instr_pc, 32'h3000 + 32'(4 * k));
            check("zw_instr", instr, (32'h3000 + 32'(4 * k)) ^ KEY);
            step();
            check("zw_valid_lo", {31'd0, instr_valid}, 32'd0);
        end

        // Three wait cycles on the first fetch
        auto_ack = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            check("ws_req", {31'd0, imem.imem_req}, 32'd1);
            check("ws_addr", imem.imem_addr, 32'h3000);
            check("ws_valid", {31'd0, instr_valid}, 32'd0);
        end
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        check("ws_valid_hi", {31'd0, instr_valid}, 32'd1);
        check("ws_pc", pc, 32'h3004);

        // Jump while fetch outstanding -> FLUSH, data discarded
        do_reset();
        step();
        j_req = 1'b1; j_target = 32'h3403;
        step();
        j_req = 1'b0;
        check("fl_pc_held", pc, 32'h3000);
        check("fl_req", {31'd0, imem.imem_req}, 32'd1);
        check("fl_valid0", {31'd0, instr_valid}, 32'd0);
        step();
        check("fl_valid1", {31'd0, instr_valid}, 32'd0);
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        check("fl_valid2", {31'd0, instr_valid}, 32'd0);
        check("fl_new_addr", imem.imem_addr, 32'h3400);
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        check("fl_fetch_pc", instr_pc, 32'h3400);

        // Jump beats branch in HOLD, redirect beats stall
        stall = 1'b1;
        br_req = 1'b1; br_target = 32'h3100;
        j_req = 1'b1; j_target = 32'h3200;
        step();
        br_req = 1'b0; j_req = 1'b0; stall = 1'b0;
        check("jb_valid", {31'd0, instr_valid}, 32'd0);
        check("jb_addr", imem.imem_addr, 32'h3200);

        // Stall holds the instruction, release resumes at instr_pc+4
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("st_valid", {31'd0, instr_valid}, 32'd1);
            check("st_instr_pc", instr_pc, 32'h3200);
            check("st_instr", instr, 32'h3200 ^ KEY);
            check("st_req", {31'd0, imem.imem_req}, 32'd0);
        end
        stall = 1'b0;
        step();
        check("st_resume_addr", imem.imem_addr, 32'h3204);
        check("st_resume_req", {31'd0, imem.imem_req}, 32'd1);

        // Reset in FLUSH; the following ack is ignored in IDLE
        j_req = 1'b1; j_target = 32'h3500;
        step();
        j_req = 1'b0;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("rf_pc", pc, 32'h3000);
        check("rf_req", {31'd0, imem.imem_req}, 32'd0);
        check("rf_valid", {31'd0, instr_valid}, 32'd0);
        check("rf_instr_pc", instr_pc, 32'd0);
        man_ack = 1'b1;
        step();
        check("rf_idle_ack_pc", pc, 32'h3000);
        check("rf_idle_ack_valid", {31'd0, instr_valid}, 32'd0);
        step();
        man_ack = 1'b0;
        check("rf_first_fetch", instr_pc, 32'h3000);

        // Wrap: target low bits masked, pc+4 wraps to zero
        j_req = 1'b1; j_target = 32'hFFFF_FFFF;
        step();
        j_req = 1'b0;
        check("wr_addr", imem.imem_addr, 32'hFFFF_FFFC);
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        check("wr_instr_pc", instr_pc, 32'hFFFF_FFFC);
        step();
        check("wr_next_addr", imem.imem_addr, 32'h0000_0000);

        // Ack with same-cycle redirect: data dropped, stay in REQ at target
        man_ack = 1'b1; br_req = 1'b1; br_target = 32'h3600;
        step();
        man_ack = 1'b0; br_req = 1'b0;
        check("ar_valid", {31'd0, instr_valid}, 32'd0);
        check("ar_addr", imem.imem_addr, 32'h3600);
        check("ar_req", {31'd0, imem.imem_req}, 32'd1);

        // A second redirect during FLUSH overwrites the pending target
        br_req = 1'b1; br_target = 32'h3700;
        step();
        br_req = 1'b0; j_req = 1'b1; j_target = 32'h3800;
        step();
        j_req = 1'b0; man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        check("po_addr", imem.imem_addr, 32'h3800);
        check("po_valid", {31'd0, instr_valid}, 32'd0);

`ifdef FETCH_EXC_EN
        // Exception in HOLD captures instr_pc and vectors
        auto_ack = 1'b1;
        do_reset();
        for (int k = 0; k < 10; k++)
            step();
        check("ex_instr_pc", instr_pc, 32'h3010);
        exc_req = 1'b1;
        step();
        exc_req = 1'b0;
        check("ex_epc", epc, 32'h3010);
        check("ex_addr", imem.imem_addr, 32'h4180);
        auto_ack = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the program counter and the instruction-memory fetch handshake for the P4-class MIPS core.
- Owns the PC register, holds the current instruction for decode, and arbitrates redirects: jump over branch.
- Handles wait-stated instruction memory, decode stalls, and redirects that arrive while a fetch is outstanding.

Parameters:
- RESET_PC, 32'h00003000, PC value loaded on reset.
- EXC_VEC, 32'h00004180, exception vector; used only when FETCH_EXC_EN is defined.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- stall  in  1  decode hazard; holds the current instruction while 1.
- br_req  in  1  branch redirect pulse.
- br_target  in  32  branch target address.
- j_req  in  1  jump/jr redirect pulse.
- j_target  in  32  jump target address.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  data valid this cycle; may assert in the same cycle as imem_req.
- imem_rdata  in  32  fetched word.
- instr_valid  out  1  instr/instr_pc valid for decode.
- instr  out  32  held instruction.
- instr_pc  out  32  address of the held instruction.
- pc  out  32  current fetch PC.

Behaviour:
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, instr=0, instr_pc=0, pending target=0.
- Reset applies from any state. An imem_ack arriving after reset is ignored while in IDLE.
- States: IDLE, REQ, HOLD, FLUSH.
- imem_req=1 in REQ and FLUSH only. imem_addr=pc at all times.
- Redirect means j_req|br_req. If both are high, j_target wins.
- Target bits [1:0] are forced to 0. pc+4 wraps modulo 2^32.
- IDLE:
  - Always moves to REQ next cycle.
  - A redirect in this cycle loads pc=target; otherwise pc is unchanged.
- REQ, ack and no redirect:
  - instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4; go to HOLD.
- REQ, ack and redirect in the same cycle:
  - Fetched data is discarded, pc<=target, instr_valid stays 0, stay in REQ.
- REQ, no ack and redirect:
  - pending<=target; go to FLUSH; pc is unchanged.
- REQ, no ack and no redirect: stay in REQ.
- FLUSH:
  - A new redirect overwrites pending.
  - On ack, data is discarded and pc<=pending, or the same-cycle redirect target if one is present; go to REQ.
  - instr_valid=0 throughout FLUSH.
- HOLD:
  - Consumption occurs when instr_valid && !stall.
  - Redirect: instr_valid<=0, pc<=target, go to REQ. Redirect takes priority over stall.
  - stall=1 and no redirect: all outputs are held.
  - stall=0 and no redirect: instr_valid<=0, go to REQ.
- Throughput with zero-wait memory is 1 instruction per 2 cycles. Each wait cycle adds 1.
- Redirect inputs are sampled every cycle and are never queued beyond the single pending register.

Optional Feature:
- Macro: FETCH_EXC_EN.
- Defined:
  - Adds ports exc_req (in, 1) and epc (out, 32, reset 0).
  - exc_req has the highest redirect priority, with target=EXC_VEC.
  - On acceptance, epc<=instr_pc if in HOLD, else epc<=pc.
  - Accepting exc_req during FLUSH overwrites pending with EXC_VEC.
- Undefined: exc_req and epc do not exist, and redirect priority is j over br only.

Test Plan:
- Reset, zero-wait ack (ack=1 whenever imem_req=1), stall=0, rdata=addr-derived:
  - instr_pc sequence is 0x3000, 0x3004, 0x3008.
  - instr_valid pulses every 2nd cycle.
  - pc reads 0x3000 during the first REQ.
- ack delayed 3 cycles in REQ: imem_req held 3 cycles with imem_addr=0x3000 stable, then instr_valid=1 and pc=0x3004.
- Redirect while fetch outstanding:
  - j_req=1, j_target=0x3403 in REQ with ack=0 -> FLUSH.
  - ack 2 cycles later: data discarded, instr_valid never 1, next imem_addr=0x3400.
- br_req and j_req in the same HOLD cycle, with br_target=0x3100 and j_target=0x3200, and stall=1 -> instr_valid drops, next imem_addr=0x3200.
- Stall hold then release:
  - stall=1 for 4 cycles in HOLD: instr, instr_pc and instr_valid constant, imem_req=0.
  - stall=0: fetch resumes at instr_pc+4.
- Reset asserted in FLUSH with ack arriving the next cycle: outputs return to reset values, the ack is ignored, and the first fetch is at 0x3000.
- Wrap: redirect to 0xFFFFFFFC, ack, consume -> next fetch address 0x00000000.
- With FETCH_EXC_EN: exc_req in HOLD with instr_pc=0x3010 -> epc=0x3010, next imem_addr=0x4180.
